// File: rtl/aud_pkg.sv
// -----------------------------------------------------------------------------
// aud_pkg
// Shared definitions for the AUD branch-trace transmitter: symbol codes driven
// while aud_nsync=1, nibble-count mode encodings, transmitter state encoding
// and the helper that turns a mode into the index of its last nibble.
// -----------------------------------------------------------------------------
package aud_pkg;

  // Symbol shown while the link is idle (nsync=1).
  localparam logic [3:0] AUD_SYM_IDLE  = 4'b0011;
  // Upper two bits of a start symbol; the lower two carry the mode.
  localparam logic [1:0] AUD_SYM_START = 2'b10;

  // Number of address nibbles that follow a start symbol.
  localparam logic [1:0] MODE_1N = 2'd0;
  localparam logic [1:0] MODE_2N = 2'd1;
  localparam logic [1:0] MODE_4N = 2'd2;
  localparam logic [1:0] MODE_8N = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2
  } aud_state_e;

  // Index of the final nibble for a given mode: (1 << mode) - 1.
  function automatic logic [2:0] mode_nib_last(input logic [1:0] mode);
    logic [2:0] last;
    case (mode)
      MODE_1N: last = 3'd0;
      MODE_2N: last = 3'd1;
      MODE_4N: last = 3'd3;
      default: last = 3'd7;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/aud_addr_cmp.sv
// -----------------------------------------------------------------------------
// aud_addr_cmp
// Combinational mode selector: picks the smallest nibble count that lets the
// receiver rebuild addr from base (the last address it holds as good).
//   addr  [31:0] in  : address about to be sent
//   base  [31:0] in  : address the receiver will merge the nibbles into
//   mode  [1:0]  out : MODE_1N / MODE_2N / MODE_4N / MODE_8N
// COMPRESS=0 forces full 8-nibble transfers.
// -----------------------------------------------------------------------------
module aud_addr_cmp
  import aud_pkg::*;
#(
  parameter int COMPRESS = 1
) (
  input  logic [31:0] addr,
  input  logic [31:0] base,
  output logic [1:0]  mode
);

  // Longest matching upper prefix decides how many low nibbles must be sent.
  always_comb begin
    mode = MODE_8N;
    if (COMPRESS == 0) begin
      mode = MODE_8N;
    end else if (addr[31:4] == base[31:4]) begin
      mode = MODE_1N;
    end else if (addr[31:8] == base[31:8]) begin
      mode = MODE_2N;
    end else if (addr[31:16] == base[31:16]) begin
      mode = MODE_4N;
    end else begin
      mode = MODE_8N;
    end
  end

endmodule

// File: rtl/aud_btm_tx.sv
// -----------------------------------------------------------------------------
// aud_btm_tx
// AUD branch-trace transmitter. Branch addresses arrive over valid/ready into a
// one-entry holding register, are compressed against the last completely sent
// address and serialised as a start symbol plus 1/2/4/8 nibbles, LSB first.
//   aud_ck    in      : trace clock, state changes on posedge
//   rst       in      : asynchronous active-high reset
//   br_addr   in [32] : branch target address
//   br_valid  in      : br_addr valid
//   br_ready  out     : holding register empty
//   aud_data  out [4] : AUD data nibble / command symbol
//   aud_nsync out     : 1 = command phase, 0 = address nibble phase
//   busy      out     : transfer in progress or request pending
//   abort     out     : one-cycle pulse when an in-flight transfer is preempted
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module aud_btm_tx
  import aud_pkg::*;
#(
  parameter int COMPRESS      = 1,
  parameter int ALLOW_PREEMPT = 1
) (
  input  logic        aud_ck,
  input  logic        rst,
  input  logic [31:0] br_addr,
  input  logic        br_valid,
  output logic        br_ready,
  output logic [3:0]  aud_data,
  output logic        aud_nsync,
  output logic        busy,
  output logic        abort
);

  aud_state_e  state_r, state_next_s;
  logic [31:0] pend_r, pend_next_s;
  logic        pend_valid_r, pend_valid_next_s;
  logic [31:0] cur_r, cur_next_s;
  logic [31:0] last_good_r, last_good_next_s;
  logic [2:0]  nib_last_r, nib_last_next_s;
  logic [2:0]  idx_r, idx_next_s;
  logic [1:0]  mode_r, mode_next_s;
  logic [3:0]  data_next_s;
  logic        nsync_next_s;
  logic        abort_next_s;
  logic        busy_next_s;

  logic        accept_s;
  logic        complete_s;
  logic        preempt_s;
  logic [31:0] start_addr_s;
  logic [31:0] base_s;
  logic [1:0]  mode_s;

  assign accept_s   = br_valid && br_ready;
  assign complete_s = (state_r == DATA) && (idx_r == nib_last_r);
  assign preempt_s  = (state_r == DATA) && !complete_s && pend_valid_r && (ALLOW_PREEMPT != 0);

  // A request accepted on the completing edge is started directly from br_addr.
  assign start_addr_s = pend_valid_r ? pend_r : br_addr;
  // On completion the receiver will already hold cur as its good address.
  assign base_s       = complete_s ? cur_r : last_good_r;

  aud_addr_cmp #(
    .COMPRESS(COMPRESS)
  ) u_addr_cmp (
    .addr(start_addr_s),
    .base(base_s),
    .mode(mode_s)
  );

  // Next-state and next-output decode; outputs are computed one edge ahead.
  always_comb begin
    state_next_s      = state_r;
    pend_next_s       = pend_r;
    pend_valid_next_s = pend_valid_r;
    cur_next_s        = cur_r;
    last_good_next_s  = last_good_r;
    nib_last_next_s   = nib_last_r;
    idx_next_s        = idx_r;
    mode_next_s       = mode_r;
    data_next_s       = AUD_SYM_IDLE;
    nsync_next_s      = 1'b1;
    abort_next_s      = 1'b0;

    if (accept_s) begin
      pend_next_s       = br_addr;
      pend_valid_next_s = 1'b1;
    end else begin
      pend_next_s       = pend_r;
    end

    case (state_r)
      IDLE: begin
        if (pend_valid_r) begin
          state_next_s = START;
          mode_next_s  = mode_s;
          data_next_s  = {AUD_SYM_START, mode_s};
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        // br_ready is low here, so no request can land on this edge.
        cur_next_s        = pend_r;
        nib_last_next_s   = mode_nib_last(mode_r);
        idx_next_s        = 3'd0;
        pend_valid_next_s = 1'b0;
        state_next_s      = DATA;
        nsync_next_s      = 1'b0;
        data_next_s       = pend_r[3:0];
      end
      DATA: begin
        if (complete_s) begin
          last_good_next_s = cur_r;
          if (pend_valid_r || accept_s) begin
            state_next_s = START;
            mode_next_s  = mode_s;
            data_next_s  = {AUD_SYM_START, mode_s};
          end else begin
            state_next_s = IDLE;
          end
        end else if (preempt_s) begin
          // last_good stays: the receiver falls back to it on the new start.
          state_next_s = START;
          mode_next_s  = mode_s;
          data_next_s  = {AUD_SYM_START, mode_s};
          abort_next_s = 1'b1;
        end else begin
          idx_next_s   = idx_r + 3'd1;
          nsync_next_s = 1'b0;
          data_next_s  = cur_r[{idx_next_s, 2'b00} +: 4];
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    busy_next_s = (state_next_s != IDLE) || pend_valid_next_s;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge aud_ck or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      pend_r       <= 32'h0000_0000;
      pend_valid_r <= 1'b0;
      cur_r        <= 32'h0000_0000;
      last_good_r  <= 32'h0000_0000;
      nib_last_r   <= 3'd0;
      idx_r        <= 3'd0;
      mode_r       <= MODE_1N;
      aud_data     <= AUD_SYM_IDLE;
      aud_nsync    <= 1'b1;
      br_ready     <= 1'b1;
      busy         <= 1'b0;
      abort        <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pend_r       <= pend_next_s;
      pend_valid_r <= pend_valid_next_s;
      cur_r        <= cur_next_s;
      last_good_r  <= last_good_next_s;
      nib_last_r   <= nib_last_next_s;
      idx_r        <= idx_next_s;
      mode_r       <= mode_next_s;
      aud_data     <= data_next_s;
      aud_nsync    <= nsync_next_s;
      br_ready     <= !pend_valid_next_s;
      busy         <= busy_next_s;
      abort        <= abort_next_s;
    end
  end

endmodule

// File: tb/tb_aud_btm_tx.sv
// -----------------------------------------------------------------------------
// tb_aud_btm_tx
// Scoreboard bench for aud_btm_tx. Two instances: u_dut_a preempts, u_dut_b
// waits. Expected symbol streams and decoded addresses are queued when a request
// is driven; a negedge monitor pops and compares them and also acts as a
// receiver that rebuilds addresses from the nibbles.
// -----------------------------------------------------------------------------
module tb_aud_btm_tx;

  logic        aud_ck = 1'b0;
  logic        rst = 1'b0;
  logic        sel_b = 1'b0;
  logic        drv_valid = 1'b0;
  logic [31:0] drv_addr = 32'h0;

  logic        ready_a, nsync_a, busy_a, abort_a;
  logic [3:0]  data_a;
  logic        ready_b, nsync_b, busy_b, abort_b;
  logic [3:0]  data_b;
  logic        valid_a, valid_b;

  logic        mon_ready, mon_nsync, mon_busy, mon_abort;
  logic [3:0]  mon_data;

  always #5 aud_ck = ~aud_ck;

  assign valid_a   = drv_valid & ~sel_b;
  assign valid_b   = drv_valid & sel_b;
  assign mon_ready = sel_b ? ready_b : ready_a;
  assign mon_nsync = sel_b ? nsync_b : nsync_a;
  assign mon_busy  = sel_b ? busy_b  : busy_a;
  assign mon_abort = sel_b ? abort_b : abort_a;
  assign mon_data  = sel_b ? data_b  : data_a;

  aud_btm_tx #(.COMPRESS(1), .ALLOW_PREEMPT(1)) u_dut_a (
    .aud_ck(aud_ck), .rst(rst), .br_addr(drv_addr), .br_valid(valid_a),
    .br_ready(ready_a), .aud_data(data_a), .aud_nsync(nsync_a),
    .busy(busy_a), .abort(abort_a)
  );

  aud_btm_tx #(.COMPRESS(1), .ALLOW_PREEMPT(0)) u_dut_b (
    .aud_ck(aud_ck), .rst(rst), .br_addr(drv_addr), .br_valid(valid_b),
    .br_ready(ready_b), .aud_data(data_b), .aud_nsync(nsync_b),
    .busy(busy_b), .abort(abort_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0]  exp_q[$];
  logic [31:0] rx_exp[$];
  logic [31:0] m_last_good = 32'h0;

  // receiver / monitor state
  int          rx_left = 0;
  int          rx_idx = 0;
  logic [31:0] rx_acc = 32'h0;
  logic [31:0] rx_last = 32'h0;
  int          rx_aborts = 0;
  int          abort_cnt = 0;
  logic        prev_idle = 1'b1;
  logic        start_prev_idle = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_mode(input logic [31:0] a, input logic [31:0] b);
    if (a[31:4] == b[31:4])        return 2'd0;
    else if (a[31:8] == b[31:8])   return 2'd1;
    else if (a[31:16] == b[31:16]) return 2'd2;
    else                           return 2'd3;
  endfunction

  // start symbol plus the first k nibbles, base = model last good
  task automatic push_partial(input logic [31:0] a, input int k);
    logic [1:0] m;
    m = model_mode(a, m_last_good);
    exp_q.push_back({1'b1, 2'b10, m});
    for (int i = 0; i < k; i++) exp_q.push_back({1'b0, a[4*i +: 4]});
  endtask

  task automatic push_xfer(input logic [31:0] a);
    logic [1:0] m;
    m = model_mode(a, m_last_good);
    push_partial(a, 1 << m);
    m_last_good = a;
    rx_exp.push_back(a);
  endtask

  // call between a negedge and the next posedge
  task automatic drive_req(input logic [31:0] a);
    int n;
    n = 0;
    drv_addr  = a;
    drv_valid = 1'b1;
    while (!mon_ready && n < 100) begin
      @(negedge aud_ck);
      n++;
    end
    if (n >= 100) check("req_timeout", n, 0);
    @(posedge aud_ck);
    #1;
    drv_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a);
    @(negedge aud_ck);
    drive_req(a);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge aud_ck);
      #1;
      if (exp_q.size() == 0 && !mon_busy) break;
    end
    if (i >= 300) check("idle_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_nibbles(input int k);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge aud_ck);
      #1;
      if (rx_idx == k && rx_left != 0) break;
    end
    if (i >= 100) check("nibble_timeout", rx_idx, k);
  endtask

  task automatic do_reset();
    @(negedge aud_ck);
    rst = 1'b1;
    exp_q.delete();
    rx_exp.delete();
    m_last_good = 32'h0;
    @(negedge aud_ck);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: scoreboard compare plus a receiver model rebuilding addresses.
  always @(negedge aud_ck) begin
    logic [4:0] sym;
    sym = {mon_nsync, mon_data};
    if (rst) begin
      rx_left   = 0;
      rx_idx    = 0;
      rx_last   = 32'h0;
      prev_idle = 1'b1;
    end else begin
      if (mon_abort) abort_cnt++;
      if (sym == 5'b1_0011) begin
        if (rx_left != 0) check("idle_gap", rx_left, 0);
        prev_idle = 1'b1;
      end else begin
        if (exp_q.size() == 0) check("unexpected_sym", {27'd0, sym}, {27'd0, 5'b1_0011});
        else check("sym", {27'd0, sym}, {27'd0, exp_q.pop_front()});
        if (sym[4]) begin
          start_prev_idle = prev_idle;
          if (rx_left != 0) rx_aborts++;
          rx_left = 1 << sym[1:0];
          rx_idx  = 0;
          rx_acc  = rx_last;
        end else if (rx_left == 0) begin
          check("stray_nibble", rx_left, 1);
        end else begin
          rx_acc[4*rx_idx +: 4] = sym[3:0];
          rx_idx++;
          rx_left--;
          if (rx_left == 0) begin
            rx_last = rx_acc;
            if (rx_exp.size() == 0) check("rx_unexpected", rx_exp.size(), 1);
            else check("rx_addr", rx_acc, rx_exp.pop_front());
          end
        end
        prev_idle = 1'b0;
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    @(negedge aud_ck);
    @(negedge aud_ck);
    #1;
    check("rst_nsync", mon_nsync, 1);
    check("rst_data", mon_data, 4'b0011);
    check("rst_ready", mon_ready, 1);
    check("rst_busy", mon_busy, 0);
    check("rst_abort", mon_abort, 0);
    rst = 1'b0;

    // compression sequence against the previous good address
    push_xfer(32'h1234_5678); send(32'h1234_5678); wait_idle();
    push_xfer(32'h1234_5679); send(32'h1234_5679); wait_idle();
    push_xfer(32'h1234_56A0); send(32'h1234_56A0); wait_idle();
    push_xfer(32'h1234_FFFF); send(32'h1234_FFFF); wait_idle();

    // back-to-back: second request lands on the completing edge
    push_xfer(32'h0000_0010); send(32'h0000_0010);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(negedge aud_ck);
      #1;
    end
    push_xfer(32'h0000_0020);
    drive_req(32'h0000_0020);
    wait_idle();
    check("b2b_gap", start_prev_idle, 0);

    // preemption from a fresh reset (base 0)
    do_reset();
    push_partial(32'hAABB_CCDD, 4);
    send(32'hAABB_CCDD);
    wait_nibbles(3);
    push_xfer(32'h0000_0005);
    drive_req(32'h0000_0005);
    wait_idle();
    check("abort_pulses", abort_cnt, 1);
    check("rx_aborts", rx_aborts, 1);
    // aborted address must not have become the base
    push_xfer(32'hAABB_CCD0); send(32'hAABB_CCD0); wait_idle();

    // asynchronous reset mid-transfer
    push_partial(32'h1234_0000, 8);
    send(32'h1234_0000);
    wait_nibbles(2);
    @(posedge aud_ck);
    #2;
    rst = 1'b1;
    exp_q.delete();
    rx_exp.delete();
    m_last_good = 32'h0;
    #1;
    check("arst_nsync", mon_nsync, 1);
    check("arst_data", mon_data, 4'b0011);
    check("arst_ready", mon_ready, 1);
    check("arst_busy", mon_busy, 0);
    @(negedge aud_ck);
    #1;
    rst = 1'b0;
    push_xfer(32'h0000_0003); send(32'h0000_0003); wait_idle();

    // no-preempt instance: pending request waits for completion
    sel_b = 1'b1;
    do_reset();
    push_xfer(32'hAABB_CCDD);
    send(32'hAABB_CCDD);
    wait_nibbles(3);
    push_xfer(32'h0000_0005);
    drive_req(32'h0000_0005);
    check("b_ready_held", mon_ready, 0);
    for (int i = 0; i < 100 && exp_q.size() > 9; i++) begin
      @(negedge aud_ck);
      #1;
    end
    check("b_ready_before_start", mon_ready, 0);
    wait_idle();
    check("b_no_abort", abort_cnt, 1);
    check("b_gap", start_prev_idle, 0);
    check("b_rx_aborts", rx_aborts, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
